// File: rtl/cr_mem_arbiter_if.sv
// cr_mem_arbiter_if: CPU, loader and memory-side signals of the shared ROM/RAM port arbiter.
// slave = arbiter view, master = CPU decode / loader / memory controller view.
interface cr_mem_arbiter_if #(
  parameter int unsigned ADDR_W = 24
);
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [7:0]        cpu_din;
  logic [7:0]        cpu_dout;
  logic              cpu_valid;
  logic              cpu_ovf;
  logic              dl_req;
  logic [ADDR_W-1:0] dl_addr;
  logic [7:0]        dl_din;
  logic              dl_ack;
  logic              cache_inv;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_din;
  logic [7:0]        mem_dout;
  logic              mem_ack;
  logic              busy;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_din,
    output cpu_dout, cpu_valid, cpu_ovf,
    input  dl_req, dl_addr, dl_din,
    output dl_ack,
    input  cache_inv,
    output mem_req, mem_we, mem_addr, mem_din,
    input  mem_dout, mem_ack,
    output busy
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_din,
    input  cpu_dout, cpu_valid, cpu_ovf,
    output dl_req, dl_addr, dl_din,
    input  dl_ack,
    output cache_inv,
    input  mem_req, mem_we, mem_addr, mem_din,
    output mem_dout, mem_ack,
    input  busy
  );
endinterface

// File: rtl/cr_mem_arbiter.sv
// cr_mem_arbiter: shares one ROM/RAM port between buffered CPU accesses and the ROM loader,
// CPU-priority with loader anti-starvation. Define CR_ARB_CACHE_EN for a one-entry read cache.
module cr_mem_arbiter #(
  parameter int unsigned ADDR_W     = 24,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic            clk,
  input  logic            reset_n,
  cr_mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    GNT_CPU,
    GNT_DL
  } state_e;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  state_e            state_q;
  logic              cpu_pend_q;
  logic              cpu_we_q;
  logic [ADDR_W-1:0] cpu_addr_q;
  logic [7:0]        cpu_din_q;
  logic [3:0]        starve_q;
  logic              mem_req_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [7:0]        mem_din_q;
  logic [7:0]        cpu_dout_q;
  logic              cpu_valid_q;
  logic              cpu_ovf_q;
  logic              dl_ack_q;

  logic              cpu_done;
  logic              cpu_acc;
  logic              cpu_hit;
  logic              cpu_miss;
  logic              cpu_want;
  logic              dl_want;
  logic              dl_force;
  logic [7:0]        hit_data;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [7:0]        sel_din;

`ifdef CR_ARB_CACHE_EN
  logic              cache_vld_q;
  logic [ADDR_W-1:0] cache_addr_q;
  logic [7:0]        cache_data_q;

  // Hits are only served with the buffer empty so they never merge with a completion pulse.
  assign cpu_hit  = bus.cpu_req && !cpu_pend_q && !bus.cpu_we && cache_vld_q &&
                    (cache_addr_q == bus.cpu_addr);
  assign hit_data = cache_data_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cache_vld_q  <= 1'b0;
      cache_addr_q <= '0;
      cache_data_q <= '0;
    end else if (bus.cache_inv) begin
      cache_vld_q <= 1'b0;
    end else if ((state_q != IDLE) && bus.mem_ack) begin
      if ((state_q == GNT_CPU) && !mem_we_q) begin
        cache_vld_q  <= 1'b1;
        cache_addr_q <= mem_addr_q;
        cache_data_q <= bus.mem_dout;
      end else if (cache_vld_q && (cache_addr_q == mem_addr_q)) begin
        cache_data_q <= mem_din_q;
      end
    end
  end
`else
  assign cpu_hit  = 1'b0;
  assign hit_data = '0;
`endif

  always_comb begin
    cpu_done = (state_q == GNT_CPU) && bus.mem_ack;
    cpu_acc  = bus.cpu_req && (!cpu_pend_q || cpu_done);
    cpu_miss = cpu_acc && !cpu_hit;
    cpu_want = cpu_pend_q || cpu_miss;
    // dl_req is still high in the cycle dl_ack is visible; that cycle must not re-grant it.
    dl_want  = bus.dl_req && !dl_ack_q;
    dl_force = dl_want && (starve_q == STARVE_LIM);
    sel_we   = cpu_pend_q ? cpu_we_q   : bus.cpu_we;
    sel_addr = cpu_pend_q ? cpu_addr_q : bus.cpu_addr;
    sel_din  = cpu_pend_q ? cpu_din_q  : bus.cpu_din;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      cpu_pend_q  <= 1'b0;
      cpu_we_q    <= 1'b0;
      cpu_addr_q  <= '0;
      cpu_din_q   <= '0;
      starve_q    <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_din_q   <= '0;
      cpu_dout_q  <= '0;
      cpu_valid_q <= 1'b0;
      cpu_ovf_q   <= 1'b0;
      dl_ack_q    <= 1'b0;
    end else begin
      cpu_valid_q <= 1'b0;
      cpu_ovf_q   <= bus.cpu_req && !cpu_acc;
      dl_ack_q    <= 1'b0;

      if (cpu_miss) begin
        cpu_pend_q <= 1'b1;
        cpu_we_q   <= bus.cpu_we;
        cpu_addr_q <= bus.cpu_addr;
        cpu_din_q  <= bus.cpu_din;
      end else if (cpu_done) begin
        cpu_pend_q <= 1'b0;
      end

      if (cpu_hit) begin
        cpu_valid_q <= 1'b1;
        cpu_dout_q  <= hit_data;
      end

      case (state_q)
        IDLE: begin
          if (cpu_want && !dl_force) begin
            state_q    <= GNT_CPU;
            mem_req_q  <= 1'b1;
            mem_we_q   <= sel_we;
            mem_addr_q <= sel_addr;
            mem_din_q  <= sel_din;
          end else if (dl_want) begin
            state_q    <= GNT_DL;
            mem_req_q  <= 1'b1;
            mem_we_q   <= 1'b1;
            mem_addr_q <= bus.dl_addr;
            mem_din_q  <= bus.dl_din;
          end
        end
        GNT_CPU: begin
          if (bus.mem_ack) begin
            state_q     <= IDLE;
            mem_req_q   <= 1'b0;
            cpu_valid_q <= 1'b1;
            if (!mem_we_q) begin
              cpu_dout_q <= bus.mem_dout;
            end
            if (bus.dl_req) begin
              starve_q <= (starve_q >= STARVE_LIM) ? STARVE_LIM : starve_q + 4'd1;
            end else begin
              starve_q <= '0;
            end
          end
        end
        GNT_DL: begin
          if (bus.mem_ack) begin
            state_q   <= IDLE;
            mem_req_q <= 1'b0;
            dl_ack_q  <= 1'b1;
            starve_q  <= '0;
          end
        end
        default: begin
          state_q   <= IDLE;
          mem_req_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_din   = mem_din_q;
  assign bus.cpu_dout  = cpu_dout_q;
  assign bus.cpu_valid = cpu_valid_q;
  assign bus.cpu_ovf   = cpu_ovf_q;
  assign bus.dl_ack    = dl_ack_q;
  assign bus.busy      = (state_q != IDLE) || cpu_pend_q;

endmodule

// File: tb/tb_cr_mem_arbiter.sv
// tb_cr_mem_arbiter: directed stimulus with a queue scoreboard; a negedge monitor pops
// expected memory grants, CPU completions, loader acks and overflow pulses.
module tb_cr_mem_arbiter;

  typedef struct {
    logic        we;
    logic [23:0] addr;
    logic [7:0]  din;
  } mem_exp_t;

  typedef struct {
    logic [7:0]  data;
    bit          hit;
    int unsigned req_cyc;
  } cpu_exp_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  int unsigned cyc = 0;
  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned ack_delay = 1;
  int unsigned ack_cyc = 0;
  int unsigned rise_cyc = 0;
  int unsigned valid_cyc = 0;
  logic [23:0] last_grant_addr = '0;
  logic        prev_req = 1'b0;
  logic [7:0]  exp_last = '0;

  mem_exp_t    exp_mem[$];
  cpu_exp_t    exp_cpu[$];
  logic [23:0] exp_dl[$];
  int unsigned exp_ovf[$];

  cr_mem_arbiter_if #(.ADDR_W(24)) bus ();

  cr_mem_arbiter #(.ADDR_W(24), .STARVE_MAX(4)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] mdata(input logic [23:0] a);
    return a[7:0] ^ 8'h4A;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_mem(input logic we, input logic [23:0] a, input logic [7:0] d);
    mem_exp_t e;
    e.we = we; e.addr = a; e.din = d;
    exp_mem.push_back(e);
  endtask

  task automatic push_cpu(input logic [7:0] d, input bit hit);
    cpu_exp_t e;
    e.data = d; e.hit = hit; e.req_cyc = cyc;
    exp_cpu.push_back(e);
    exp_last = d;
  endtask

  task automatic cpu_issue(input logic we, input logic [23:0] a, input logic [7:0] d);
    bus.cpu_req = 1'b1; bus.cpu_we = we; bus.cpu_addr = a; bus.cpu_din = d;
    tick();
    bus.cpu_req = 1'b0;
  endtask

  task automatic wait_idle(input int unsigned maxc);
    int unsigned n = 0;
    tick();
    while ((bus.busy || bus.mem_req) && n < maxc) begin
      tick();
      n++;
    end
    chk("idle_timeout", 64'(n >= maxc), 64'(0));
    tick();
    tick();
  endtask

  task automatic wait_ack(input int unsigned maxc);
    int unsigned n = 0;
    do begin
      @(posedge clk); #2;
      n++;
    end while (!bus.mem_ack && n < maxc);
    chk("ack_timeout", 64'(bus.mem_ack), 64'(1));
  endtask

  task automatic wait_dl_ack(input int unsigned maxc);
    int unsigned n = 0;
    do begin
      @(posedge clk); #2;
      n++;
    end while (!bus.dl_ack && n < maxc);
    chk("dl_ack_timeout", 64'(bus.dl_ack), 64'(1));
    bus.dl_req = 1'b0;
  endtask

  // Memory controller model: acks ack_delay cycles after mem_req is first seen.
  initial begin
    int unsigned w;
    w = 0;
    bus.mem_ack = 1'b0;
    bus.mem_dout = '0;
    forever begin
      @(posedge clk); #1;
      bus.mem_ack = 1'b0;
      if (bus.mem_req) begin
        if (w >= ack_delay) begin
          bus.mem_ack = 1'b1;
          bus.mem_dout = bus.mem_we ? 8'h00 : mdata(bus.mem_addr);
          w = 0;
        end else begin
          w++;
        end
      end else begin
        w = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (!reset_n) begin
      prev_req = 1'b0;
    end else begin
      if (bus.mem_req && !prev_req) begin
        rise_cyc = cyc;
        last_grant_addr = bus.mem_addr;
        chk("mem_grant_expected", 64'(exp_mem.size() != 0), 64'(1));
        if (exp_mem.size() != 0) begin
          mem_exp_t e;
          e = exp_mem.pop_front();
          chk("mem_txn", 64'({bus.mem_we, bus.mem_addr, bus.mem_din}), 64'({e.we, e.addr, e.din}));
        end
      end
      prev_req = bus.mem_req;
      if (bus.mem_req && bus.mem_ack) ack_cyc = cyc;
      if (bus.cpu_valid) begin
        valid_cyc = cyc;
        chk("cpu_valid_expected", 64'(exp_cpu.size() != 0), 64'(1));
        if (exp_cpu.size() != 0) begin
          cpu_exp_t e;
          e = exp_cpu.pop_front();
          chk("cpu_dout", 64'(bus.cpu_dout), 64'(e.data));
          if (e.hit) chk("hit_latency", 64'(cyc), 64'(e.req_cyc + 1));
          else       chk("valid_after_ack", 64'(cyc), 64'(ack_cyc + 1));
        end
      end
      if (bus.dl_ack) begin
        chk("dl_ack_expected", 64'(exp_dl.size() != 0), 64'(1));
        if (exp_dl.size() != 0) begin
          logic [23:0] a;
          a = exp_dl.pop_front();
          chk("dl_ack_addr", 64'(last_grant_addr), 64'(a));
          chk("dl_ack_after_ack", 64'(cyc), 64'(ack_cyc + 1));
        end
      end
      if (bus.cpu_ovf) begin
        chk("ovf_expected", 64'(exp_ovf.size() != 0), 64'(1));
        if (exp_ovf.size() != 0) chk("ovf_cycle", 64'(cyc), 64'(exp_ovf.pop_front()));
      end
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached, errors so far %0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned t1_req;
    int unsigned n;
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_din = '0;
    bus.dl_req = 1'b0; bus.dl_addr = '0; bus.dl_din = '0; bus.cache_inv = 1'b0;
    repeat (3) tick();
    chk("rst_mem_req",   64'(bus.mem_req),   64'(0));
    chk("rst_cpu_valid", 64'(bus.cpu_valid), 64'(0));
    chk("rst_cpu_ovf",   64'(bus.cpu_ovf),   64'(0));
    chk("rst_dl_ack",    64'(bus.dl_ack),    64'(0));
    chk("rst_busy",      64'(bus.busy),      64'(0));
    chk("rst_cpu_dout",  64'(bus.cpu_dout),  64'(0));
    @(negedge clk) reset_n = 1'b1;
    tick(); tick();

    // Read 0x4010, ack two cycles after mem_req
    ack_delay = 2;
    push_mem(1'b0, 24'h004010, 8'h00);
    push_cpu(8'h5A, 1'b0);
    t1_req = cyc;
    cpu_issue(1'b0, 24'h004010, 8'h00);
    wait_idle(50);
    chk("t1_grant_latency", 64'(rise_cyc - t1_req), 64'(1));
    chk("t1_valid_latency", 64'(valid_cyc - t1_req), 64'(4));

    // CPU and loader in the same idle cycle: CPU first
    ack_delay = 1;
    push_mem(1'b1, 24'h002000, 8'h33);
    push_mem(1'b1, 24'h003000, 8'h77);
    push_cpu(exp_last, 1'b0);
    exp_dl.push_back(24'h003000);
    bus.dl_req = 1'b1; bus.dl_addr = 24'h003000; bus.dl_din = 8'h77;
    cpu_issue(1'b1, 24'h002000, 8'h33);
    wait_dl_ack(50);
    wait_idle(50);

    // Starvation: four CPU grants, then the loader, then the buffered CPU read
    bus.dl_req = 1'b1; bus.dl_addr = 24'h003100; bus.dl_din = 8'h88;
    exp_dl.push_back(24'h003100);
    push_mem(1'b0, 24'h000100, 8'h00);
    push_cpu(mdata(24'h000100), 1'b0);
    cpu_issue(1'b0, 24'h000100, 8'h00);
    for (int i = 1; i <= 4; i++) begin
      logic [23:0] a;
      a = 24'h000100 + 24'(i);
      wait_ack(50);
      if (i == 4) push_mem(1'b1, 24'h003100, 8'h88);
      push_mem(1'b0, a, 8'h00);
      push_cpu(mdata(a), 1'b0);
      bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = a; bus.cpu_din = 8'h00;
      tick();
      bus.cpu_req = 1'b0;
    end
    wait_dl_ack(100);
    wait_idle(50);

    // Overflow while stalled; a loader request withdrawn before any grant
    ack_delay = 6;
    push_mem(1'b0, 24'h004444, 8'h00);
    push_cpu(mdata(24'h004444), 1'b0);
    cpu_issue(1'b0, 24'h004444, 8'h00);
    tick();
    exp_ovf.push_back(cyc + 1);
    cpu_issue(1'b0, 24'h005555, 8'h00);
    bus.dl_req = 1'b1; bus.dl_addr = 24'h006000; bus.dl_din = 8'hEE;
    tick(); tick();
    bus.dl_req = 1'b0;
    wait_idle(50);

    // Stray mem_ack while idle
    @(posedge clk); #2;
    bus.mem_ack = 1'b1;
    tick(); tick();
    chk("stray_ack_busy",    64'(bus.busy),    64'(0));
    chk("stray_ack_mem_req", 64'(bus.mem_req), 64'(0));

    // Loader drops dl_req after its grant: access still completes
    ack_delay = 3;
    push_mem(1'b1, 24'h003200, 8'h99);
    exp_dl.push_back(24'h003200);
    bus.dl_req = 1'b1; bus.dl_addr = 24'h003200; bus.dl_din = 8'h99;
    n = 0;
    while (!bus.mem_req && n < 10) begin
      tick();
      n++;
    end
    chk("dl_grant_seen", 64'(bus.mem_req), 64'(1));
    bus.dl_req = 1'b0;
    wait_idle(50);

    // Reset in the middle of an access
    ack_delay = 100;
    push_mem(1'b0, 24'h007777, 8'h00);
    cpu_issue(1'b0, 24'h007777, 8'h00);
    tick();
    chk("t5_req_up", 64'(bus.mem_req), 64'(1));
    reset_n = 1'b0;
    #1;
    chk("t5_mem_req",   64'(bus.mem_req),   64'(0));
    chk("t5_busy",      64'(bus.busy),      64'(0));
    chk("t5_cpu_valid", 64'(bus.cpu_valid), 64'(0));
    chk("t5_cpu_dout",  64'(bus.cpu_dout),  64'(0));
    exp_last = 8'h00;
    ack_delay = 1;
    @(negedge clk) reset_n = 1'b1;
    tick(); tick(); tick();
    chk("t5_after_busy",    64'(bus.busy),    64'(0));
    chk("t5_after_mem_req", 64'(bus.mem_req), 64'(0));

`ifdef CR_ARB_CACHE_EN
    push_mem(1'b0, 24'h008000, 8'h00);
    push_cpu(mdata(24'h008000), 1'b0);
    cpu_issue(1'b0, 24'h008000, 8'h00);
    wait_idle(50);
    push_cpu(mdata(24'h008000), 1'b1);
    cpu_issue(1'b0, 24'h008000, 8'h00);
    wait_idle(50);
    push_mem(1'b1, 24'h008000, 8'h11);
    push_cpu(exp_last, 1'b0);
    cpu_issue(1'b1, 24'h008000, 8'h11);
    wait_idle(50);
    push_cpu(8'h11, 1'b1);
    cpu_issue(1'b0, 24'h008000, 8'h00);
    wait_idle(50);
    bus.cache_inv = 1'b1;
    tick();
    bus.cache_inv = 1'b0;
    push_mem(1'b0, 24'h008000, 8'h00);
    push_cpu(mdata(24'h008000), 1'b0);
    cpu_issue(1'b0, 24'h008000, 8'h00);
    wait_idle(50);
`endif

    tick(); tick();
    chk("left_mem_exp", 64'(exp_mem.size()), 64'(0));
    chk("left_cpu_exp", 64'(exp_cpu.size()), 64'(0));
    chk("left_dl_exp",  64'(exp_dl.size()),  64'(0));
    chk("left_ovf_exp", 64'(exp_ovf.size()), 64'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
